// File: rtl/wa_ctrl.sv
// wa_ctrl: write-side address controller for the 4-channel sample memory.
// Fills a circular buffer of BANK*depth_sel entries around a pattern trigger,
// keeping a programmable number of pre-trigger samples, and publishes the
// address of the trigger sample for the read side.
// Optional build macro WA_EDGE_TRIG_EN: the trigger additionally requires a
// change on at least one masked channel relative to the previous cycle.
module wa_ctrl #(
    parameter int ADDR_W = 13,
    parameter int CH     = 4,
    parameter int BANK   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [CH-1:0]     channels,
    input  logic [CH-1:0]     trig_mask,
    input  logic [CH-1:0]     trig_pattern,
    input  logic [3:0]        depth_sel,
    input  logic [ADDR_W-1:0] pre_samples,
    output logic              wr_en,
    output logic [ADDR_W-1:0] write_address,
    output logic [CH-1:0]     wr_data,
    output logic [ADDR_W-1:0] trig_address,
    output logic              capturing,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    state_t            state_q, state_d;

    // Capture geometry latched at arm: highest buffer address (D-1) and the
    // number of samples still to be written after the trigger (D-P-1).
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] post_q, post_d;

    // Next address to write and the pre/post sample down-counter.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_inc;

    // Geometry derived from the live depth/pre inputs, used only on arm.
    logic [ADDR_W-1:0] arm_last;
    logic [ADDR_W-1:0] arm_pre;

    // Per-cycle actions decided by the FSM and applied by the output stage.
    logic              write;
    logic              trig_hit;
    logic              start;
    logic              finish;

    logic              level_match;
    logic              match;

    // Buffer depth decode; unsupported multipliers fall back to one bank.
    always_comb begin
        arm_last = ADDR_W'(BANK - 1);
        case (depth_sel)
            4'd2:    arm_last = ADDR_W'(2 * BANK - 1);
            4'd4:    arm_last = ADDR_W'(4 * BANK - 1);
            4'd8:    arm_last = ADDR_W'(8 * BANK - 1);
            default: arm_last = ADDR_W'(BANK - 1);
        endcase
        arm_pre = (pre_samples > arm_last) ? arm_last : pre_samples;
    end

    // Circular address increment within the latched depth.
    always_comb begin
        addr_inc = (addr_q == last_q) ? '0 : addr_q + 1'b1;
    end

    // Pattern comparison over the masked channels only.
    always_comb begin
        level_match = ((channels ^ trig_pattern) & trig_mask) == '0;
    end

`ifdef WA_EDGE_TRIG_EN
    logic [CH-1:0] prev_q;

    // Previous-cycle sample, taken every cycle so the first WAIT_TRIG cycle
    // after arm compares against the sample present on the arm cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= channels;
        end
    end

    // Pattern must hold and at least one masked channel must have changed.
    always_comb begin
        match = level_match && (((channels ^ prev_q) & trig_mask) != '0);
    end
`else
    // Pure level/pattern trigger.
    always_comb begin
        match = level_match;
    end
`endif

    // FSM state and capture bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= '0;
            post_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            post_q  <= post_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and per-cycle write/trigger decisions.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        post_d   = post_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        write    = 1'b0;
        trig_hit = 1'b0;
        start    = 1'b0;
        finish   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    start   = 1'b1;
                    last_d  = arm_last;
                    post_d  = arm_last - arm_pre;
                    cnt_d   = arm_pre;
                    addr_d  = '0;
                    state_d = (arm_pre == '0) ? WAIT_TRIG : PRE;
                end
            end

            PRE: begin
                write  = 1'b1;
                addr_d = addr_inc;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == ADDR_W'(1)) begin
                    state_d = WAIT_TRIG;
                end
            end

            WAIT_TRIG: begin
                write  = 1'b1;
                addr_d = addr_inc;
                if (match) begin
                    trig_hit = 1'b1;
                    cnt_d    = post_q;
                    if (post_q == '0) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = POST;
                    end
                end
            end

            POST: begin
                write  = 1'b1;
                addr_d = addr_inc;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == ADDR_W'(1)) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered memory interface, trigger address and completion flag.
    // done rises on the same edge that presents the final write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en         <= 1'b0;
            write_address <= '0;
            wr_data       <= '0;
            trig_address  <= '0;
            done          <= 1'b0;
        end else begin
            wr_en <= write;
            if (write) begin
                write_address <= addr_q;
                wr_data       <= channels;
            end else if (start) begin
                write_address <= '0;
            end
            if (trig_hit) begin
                trig_address <= addr_q;
            end
            if (start) begin
                done <= 1'b0;
            end else if (finish) begin
                done <= 1'b1;
            end
        end
    end

    // Capture-active indicator decoded from the state register.
    always_comb begin
        capturing = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
    end

endmodule
